// File: rtl/ahb_pkg.sv
// Shared AHB constants and the SRAM slave FSM state encoding.
// The memory access unit imports the same definitions.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'b000,
        SIZE_HALF = 3'b001,
        SIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Wait-state counter width, enough for 0..15 wait states.
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/sram_be_array.sv
// Word-wide SRAM array: synchronous byte-enable write, asynchronous read.
module sram_be_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    // Commit enabled byte lanes at the clock edge; other lanes keep their value.
    // NOTE: the array has no reset so it maps onto SRAM macros/LUT RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: address-phase capture, legality check, programmable wait
// states, two-cycle ERROR response and byte-lane write decode.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP
);

    // One past the last byte address, kept 33 bits wide so a top-of-map base cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_e                 state_q, state_d;
    logic [31:0]            addr_q;
    logic                   write_q;
    logic [2:0]             size_q;
    logic                   illegal_q;
    logic [WAIT_CNT_W-1:0]  cnt_q;

    logic                   accept;
    logic                   illegal_d;
    state_e                 accept_state;
    logic [3:0]             be;
    logic [ADDR_WIDTH-1:0]  word_idx;
    logic [31:0]            rdata;
    logic                   mem_we;

    assign accept = HREADY && HSEL && (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ);

    // Classify the incoming address phase as legal or illegal.
    always_comb begin
        illegal_d = 1'b0;
        if (HSIZE > SIZE_WORD)                           illegal_d = 1'b1;
        if (HSIZE == SIZE_WORD && HADDR[1:0] != 2'b00)   illegal_d = 1'b1;
        if (HSIZE == SIZE_HALF && HADDR[0] != 1'b0)      illegal_d = 1'b1;
        if ({1'b0, HADDR} < {1'b0, BASE_ADDR} || {1'b0, HADDR} >= LIMIT) illegal_d = 1'b1;
        if (illegal_d)             accept_state = ST_ERR1;
        else if (WAIT_STATES > 0)  accept_state = ST_WAIT;
        else                       accept_state = ST_DONE;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; DONE and ERR2 accept a pipelined transfer exactly like IDLE.
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: state_d = accept ? accept_state : ST_IDLE;
            ST_WAIT:                   if (cnt_q == '0) state_d = ST_DONE;
            ST_ERR1:                   state_d = ST_ERR2;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Bus response outputs decoded from the current state.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        unique case (state_q)
            ST_WAIT: HREADY = 1'b0;
            ST_ERR1: begin HREADY = 1'b0; HRESP = RESP_ERROR; end
            ST_ERR2: HRESP = RESP_ERROR;
            default: ;
        endcase
    end

    // Wait-state down-counter, loaded on every legal accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  cnt_q <= '0;
        else if (accept && !illegal_d)               cnt_q <= WAIT_LOAD;
        else if (state_q == ST_WAIT && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
    end

    // Capture the address-phase fields of each accepted transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            addr_q    <= HADDR;
            write_q   <= HWRITE;
            size_q    <= HSIZE;
            illegal_q <= illegal_d;
        end
    end

    // Byte-lane enables from the registered size and low address bits.
    always_comb begin
        be = 4'b0000;
        case (size_q)
            SIZE_BYTE: be[addr_q[1:0]] = 1'b1;
            SIZE_HALF: be = addr_q[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
    end

    assign word_idx = ADDR_WIDTH'((addr_q - BASE_ADDR) >> 2);
    assign mem_we   = (state_q == ST_DONE) && write_q && !illegal_q;
    assign HRDATA   = (state_q == ST_DONE && !write_q) ? rdata : 32'h0;

    sram_be_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (be),
        .addr  (word_idx),
        .wdata (HWDATA),
        .rdata (rdata)
    );

endmodule
